// File: rtl/pdp8_mem_ctrl_pkg.sv
// Shared widths, state/port enums and helpers for the PDP-8 main memory unit.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_mem_ctrl_pkg;
    localparam int AW = `ADDR_WIDTH;
    localparam int DW = `DATA_WIDTH;
    localparam int MEM_MAX_LATENCY = 4;

    typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_DONE} mem_state_t;
    typedef enum logic [1:0] {PORT_NONE, PORT_IFU, PORT_EXEC} mem_port_t;

    function automatic logic even_par(input logic [DW-1:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/pdp8_mem_ctrl_if.sv
// Request/grant/return bundle between the IFU/EXEC masters and the memory unit.
interface pdp8_mem_ctrl_if;
    logic                   ifu_rd_req;
    logic [`ADDR_WIDTH-1:0] ifu_rd_addr;
    logic                   ifu_rd_gnt;
    logic                   ifu_rd_vld;
    logic [`DATA_WIDTH-1:0] ifu_rd_data;
    logic                   exec_rd_req;
    logic [`ADDR_WIDTH-1:0] exec_rd_addr;
    logic                   exec_rd_gnt;
    logic                   exec_rd_vld;
    logic [`DATA_WIDTH-1:0] exec_rd_data;
    logic                   exec_wr_req;
    logic [`ADDR_WIDTH-1:0] exec_wr_addr;
    logic [`DATA_WIDTH-1:0] exec_wr_data;
    logic                   exec_wr_gnt;
    logic                   mem_busy;
    logic                   mem_err;

    modport master (
        output ifu_rd_req, ifu_rd_addr,
        output exec_rd_req, exec_rd_addr,
        output exec_wr_req, exec_wr_addr, exec_wr_data,
        input  ifu_rd_gnt, ifu_rd_vld, ifu_rd_data,
        input  exec_rd_gnt, exec_rd_vld, exec_rd_data,
        input  exec_wr_gnt, mem_busy, mem_err
    );

    modport slave (
        input  ifu_rd_req, ifu_rd_addr,
        input  exec_rd_req, exec_rd_addr,
        input  exec_wr_req, exec_wr_addr, exec_wr_data,
        output ifu_rd_gnt, ifu_rd_vld, ifu_rd_data,
        output exec_rd_gnt, exec_rd_vld, exec_rd_data,
        output exec_wr_gnt, mem_busy, mem_err
    );
endinterface

// File: rtl/pdp8_mem_ctrl_array.sv
// Single-port synchronous word array; MEM_PARITY_EN adds a stored even-parity
// bit checked on read, plus a flip_parity hook for fault injection.
module pdp8_mem_array
    import pdp8_mem_ctrl_pkg::*;
#(
    parameter int MEM_DEPTH = 2**`ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          perr
);
`ifdef MEM_PARITY_EN
    localparam int WW = DW + 1;
`else
    localparam int WW = DW;
`endif

    logic [WW-1:0] mem_q [MEM_DEPTH];
    logic [WW-1:0] rd_q;
    logic [WW-1:0] wword;

`ifdef MEM_PARITY_EN
    assign wword = {even_par(wdata), wdata};
    assign perr  = even_par(rd_q[DW-1:0]) != rd_q[DW];

    task automatic flip_parity(input logic [AW-1:0] a);
        mem_q[a][DW] <= ~mem_q[a][DW];
    endtask
`else
    assign wword = wdata;
    assign perr  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wword;
        rd_q <= mem_q[addr];
    end

    assign rdata = rd_q[DW-1:0];
endmodule

// File: rtl/pdp8_mem_ctrl.sv
// PDP-8 4K x 12 main memory: fixed-priority arbiter (wr > exec rd > ifu rd)
// and latency FSM in front of pdp8_mem_array. Parity option: MEM_PARITY_EN.
module pdp8_mem_ctrl
    import pdp8_mem_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int MEM_DEPTH   = 2**`ADDR_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    pdp8_mem_ctrl_if.slave bus
);
    if (MEM_LATENCY < 1 || MEM_LATENCY > MEM_MAX_LATENCY) begin : g_bad_lat
        $error("pdp8_mem_ctrl: MEM_LATENCY must be 1..4");
    end

    localparam logic [1:0] CNT_INIT =
        2'(MEM_LATENCY > 1 ? MEM_LATENCY - 2 : 0);

    mem_state_t    state_q, state_d;
    mem_port_t     port_q, port_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] ifu_data_q, ifu_data_d;
    logic [DW-1:0] exec_data_q, exec_data_d;
    logic          err_q, err_d;

    logic          accept, wr_gnt, er_gnt, if_gnt, rd_gnt;
    logic          done, ifu_vld, exec_vld, perr_hit;
    logic [AW-1:0] rd_addr, arr_addr;
    logic [DW-1:0] arr_rdata;
    logic          arr_perr;

    always_comb begin
        accept   = state_q != MEM_WAIT;
        wr_gnt   = accept & bus.exec_wr_req;
        er_gnt   = accept & bus.exec_rd_req & ~bus.exec_wr_req;
        if_gnt   = accept & bus.ifu_rd_req & ~bus.exec_wr_req
                 & ~bus.exec_rd_req;
        rd_gnt   = er_gnt | if_gnt;
        rd_addr  = er_gnt ? bus.exec_rd_addr : bus.ifu_rd_addr;
        // Between grant and DONE the latched address keeps the read port aimed.
        arr_addr = wr_gnt ? bus.exec_wr_addr : (rd_gnt ? rd_addr : addr_q);
        done     = state_q == MEM_DONE;
        ifu_vld  = done & (port_q == PORT_IFU);
        exec_vld = done & (port_q == PORT_EXEC);
        perr_hit = done & arr_perr;
    end

    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        ifu_data_d  = ifu_vld ? arr_rdata : ifu_data_q;
        exec_data_d = exec_vld ? arr_rdata : exec_data_q;
        err_d       = err_q | perr_hit
                    | (bus.exec_rd_req & bus.exec_wr_req);
        unique case (state_q)
            MEM_WAIT: begin
                if (cnt_q == 2'd0) state_d = MEM_DONE;
                else               cnt_d   = cnt_q - 2'd1;
            end
            default: begin
                state_d = MEM_IDLE;
                port_d  = PORT_NONE;
                if (rd_gnt) begin
                    port_d  = er_gnt ? PORT_EXEC : PORT_IFU;
                    addr_d  = rd_addr;
                    cnt_d   = CNT_INIT;
                    state_d = (MEM_LATENCY == 1) ? MEM_DONE : MEM_WAIT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= MEM_IDLE;
            port_q      <= PORT_NONE;
            cnt_q       <= 2'd0;
            addr_q      <= '0;
            ifu_data_q  <= '0;
            exec_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            ifu_data_q  <= ifu_data_d;
            exec_data_q <= exec_data_d;
            err_q       <= err_d;
        end
    end

    pdp8_mem_array #(.MEM_DEPTH(MEM_DEPTH)) u_array (
        .clk   (clk),
        .we    (wr_gnt),
        .addr  (arr_addr),
        .wdata (bus.exec_wr_data),
        .rdata (arr_rdata),
        .perr  (arr_perr)
    );

    assign bus.ifu_rd_gnt   = if_gnt;
    assign bus.exec_rd_gnt  = er_gnt;
    assign bus.exec_wr_gnt  = wr_gnt;
    assign bus.ifu_rd_vld   = ifu_vld;
    assign bus.exec_rd_vld  = exec_vld;
    assign bus.ifu_rd_data  = ifu_vld ? arr_rdata : ifu_data_q;
    assign bus.exec_rd_data = exec_vld ? arr_rdata : exec_data_q;
    assign bus.mem_busy     = state_q == MEM_WAIT;
    assign bus.mem_err      = err_q | perr_hit;
endmodule

// File: tb/tb_pdp8_mem_ctrl.sv
// Bench for pdp8_mem_ctrl at latencies 1, 3 and 4 against a transaction-level
// memory model plus literal spot checks; honours MEM_PARITY_EN.
module tb_pdp8_mem_ctrl;
    localparam int N = 3;
    localparam int LAT [N] = '{1, 3, 4};

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic        ir [N], er [N], wr [N];
    logic [11:0] ia [N], ea [N], wa [N], wd [N];
    logic        ig [N], eg [N], wg [N], iv [N], ev [N], bz [N], me [N];
    logic [11:0] id [N], ed [N];

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        pdp8_mem_ctrl_if b ();
        assign b.ifu_rd_req   = ir[k];
        assign b.ifu_rd_addr  = ia[k];
        assign b.exec_rd_req  = er[k];
        assign b.exec_rd_addr = ea[k];
        assign b.exec_wr_req  = wr[k];
        assign b.exec_wr_addr = wa[k];
        assign b.exec_wr_data = wd[k];
        assign ig[k] = b.ifu_rd_gnt;
        assign eg[k] = b.exec_rd_gnt;
        assign wg[k] = b.exec_wr_gnt;
        assign iv[k] = b.ifu_rd_vld;
        assign ev[k] = b.exec_rd_vld;
        assign id[k] = b.ifu_rd_data;
        assign ed[k] = b.exec_rd_data;
        assign bz[k] = b.mem_busy;
        assign me[k] = b.mem_err;
        pdp8_mem_ctrl #(.MEM_LATENCY(LAT[k])) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (b)
        );
    end

    // Model: memory image, one outstanding read with its due cycle.
    logic [11:0] mm  [N][4096];
    bit          cor [N][4096];
    bit          ob [N], op [N], operr [N], merr [N];
    int          due [N];
    logic [11:0] od [N], hi [N], he [N];
    int          cy = 0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string n, input int k,
                       input logic [11:0] a, input logic [11:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s dut%0d got=%o want=%o t=%0t", n, k, a, e, $time);
        end
    endtask

    task automatic model_cmp();
        for (int k = 0; k < N; k++) begin
            bit acc, xi, xe, xw, vi, ve, bs, pe;
            logic [11:0] di, de;
            if (reset) begin
                ob[k] = 0; merr[k] = 0; hi[k] = '0; he[k] = '0;
                vi = 0; ve = 0; bs = 0; pe = 0;
                xi = 0; xe = 0; xw = 0; di = '0; de = '0;
            end else begin
                vi  = ob[k] && due[k] == cy && !op[k];
                ve  = ob[k] && due[k] == cy && op[k];
                bs  = ob[k] && cy < due[k];
                acc = !bs;
                xw  = acc && wr[k];
                xe  = acc && er[k] && !wr[k];
                xi  = acc && ir[k] && !wr[k] && !er[k];
                pe  = (vi || ve) && operr[k];
                di  = vi ? od[k] : hi[k];
                de  = ve ? od[k] : he[k];
            end
            chk("m_ifu_gnt", k, ig[k], xi);
            chk("m_rd_gnt", k, eg[k], xe);
            chk("m_wr_gnt", k, wg[k], xw);
            chk("m_ifu_vld", k, iv[k], vi);
            chk("m_exec_vld", k, ev[k], ve);
            chk("m_busy", k, bz[k], bs);
            chk("m_err", k, me[k], merr[k] || pe);
            chk("m_ifu_data", k, id[k], di);
            chk("m_exec_data", k, ed[k], de);
            if (!reset) begin
                if (vi) hi[k] = od[k];
                if (ve) he[k] = od[k];
                if (pe || (er[k] && wr[k])) merr[k] = 1;
                if (vi || ve) ob[k] = 0;
                if (xw) begin
                    mm[k][wa[k]]  = wd[k];
                    cor[k][wa[k]] = 0;
                end
                if (xe || xi) begin
                    ob[k]    = 1;
                    op[k]    = xe;
                    due[k]   = cy + LAT[k];
                    od[k]    = mm[k][xe ? ea[k] : ia[k]];
                    operr[k] = cor[k][xe ? ea[k] : ia[k]];
                end
            end
        end
        cy++;
    endtask

    task automatic ne();
        @(negedge clk);
        model_cmp();
    endtask

    // Requesters drop req at the edge that sampled their grant.
    task automatic pe();
        bit gi [N], ge [N], gw [N];
        for (int k = 0; k < N; k++) begin
            gi[k] = ig[k]; ge[k] = eg[k]; gw[k] = wg[k];
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (gi[k]) ir[k] = 1'b0;
            if (ge[k]) er[k] = 1'b0;
            if (gw[k]) wr[k] = 1'b0;
        end
    endtask

    task automatic cyc();
        ne();
        pe();
    endtask

    task automatic wrq(input int k, input logic [11:0] a, input logic [11:0] d);
        wr[k] = 1'b1; wa[k] = a; wd[k] = d;
    endtask

    task automatic erq(input int k, input logic [11:0] a);
        er[k] = 1'b1; ea[k] = a;
    endtask

    task automatic irq(input int k, input logic [11:0] a);
        ir[k] = 1'b1; ia[k] = a;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            ir[k] = 0; er[k] = 0; wr[k] = 0;
            ia[k] = '0; ea[k] = '0; wa[k] = '0; wd[k] = '0;
        end
        ne();
        chk("rst_ifu_data", 0, id[0], 12'o0000);
        chk("rst_err", 2, me[2], 0);
        pe();
        cyc();
        reset = 1'b0;

        // Write then read-after-write at latency 1.
        wrq(0, 12'o0017, 12'o1234);
        ne(); chk("t1_wr_gnt", 0, wg[0], 1); pe();
        erq(0, 12'o0017);
        ne(); chk("t1_rd_gnt", 0, eg[0], 1); pe();
        ne();
        chk("t1_vld", 0, ev[0], 1);
        chk("t1_data", 0, ed[0], 12'o1234);
        pe();

        wrq(0, 12'o0200, 12'o5200); cyc();
        wrq(0, 12'o0300, 12'o6300); cyc();
        wrq(1, 12'o0500, 12'o1111); cyc();
        wrq(1, 12'o0501, 12'o2222); cyc();
        wrq(2, 12'o0600, 12'o3456); cyc();

        // Simultaneous IFU and EXEC reads: EXEC first.
        irq(0, 12'o0200);
        erq(0, 12'o0300);
        ne(); chk("t2_eg", 0, eg[0], 1); chk("t2_ig0", 0, ig[0], 0); pe();
        ne();
        chk("t2_ev", 0, ev[0], 1);
        chk("t2_ed", 0, ed[0], 12'o6300);
        chk("t2_iv0", 0, iv[0], 0);
        chk("t2_ig", 0, ig[0], 1);
        pe();
        ne();
        chk("t2_iv", 0, iv[0], 1);
        chk("t2_id", 0, id[0], 12'o5200);
        chk("t2_ev0", 0, ev[0], 0);
        pe();

        // Latency 3 with a second request held from the next cycle.
        irq(1, 12'o0500);
        ne(); chk("t3_ig", 1, ig[1], 1); pe();
        irq(1, 12'o0501);
        for (int c = 1; c <= 6; c++) begin
            ne();
            chk("t3_busy", 1, bz[1], (c == 1 || c == 2 || c == 4 || c == 5));
            chk("t3_vld", 1, iv[1], (c == 3 || c == 6));
            if (c < 6) chk("t3_gnt", 1, ig[1], (c == 3));
            if (c == 3) chk("t3_d0", 1, id[1], 12'o1111);
            if (c == 6) chk("t3_d1", 1, id[1], 12'o2222);
            pe();
        end

        // Read and write together: write wins, protocol error sticks.
        wrq(0, 12'o0400, 12'o4321);
        erq(0, 12'o0400);
        ne();
        chk("t4_wg", 0, wg[0], 1);
        chk("t4_eg0", 0, eg[0], 0);
        chk("t4_err0", 0, me[0], 0);
        pe();
        ne(); chk("t4_err", 0, me[0], 1); chk("t4_eg", 0, eg[0], 1); pe();
        ne();
        chk("t4_ev", 0, ev[0], 1);
        chk("t4_ed", 0, ed[0], 12'o4321);
        pe();
        repeat (3) cyc();
        ne(); chk("t4_sticky", 0, me[0], 1); pe();

        // Reset in the middle of a latency-4 read.
        erq(2, 12'o0600);
        ne(); chk("t5_eg", 2, eg[2], 1); pe();
        ne(); chk("t5_busy", 2, bz[2], 1); pe();
        reset = 1'b1;
        ne(); chk("t5_rst_busy", 2, bz[2], 0); chk("t5_rst_err", 0, me[0], 0); pe();
        reset = 1'b0;
        repeat (5) begin
            ne(); chk("t5_no_vld", 2, ev[2], 0); pe();
        end
        erq(2, 12'o0600);
        ne(); chk("t5_eg2", 2, eg[2], 1); pe();
        repeat (3) cyc();
        ne();
        chk("t5_ev", 2, ev[2], 1);
        chk("t5_ed", 2, ed[2], 12'o3456);
        pe();

        // Parity fault injection (no effect without the parity build).
        wrq(0, 12'o0700, 12'o7777);
        ne(); chk("t6_wg", 0, wg[0], 1); pe();
`ifdef MEM_PARITY_EN
        g_dut[0].u_dut.u_array.flip_parity(12'o0700);
        cor[0][12'o0700] = 1'b1;
`endif
        erq(0, 12'o0700);
        ne(); chk("t6_eg", 0, eg[0], 1); pe();
        ne();
        chk("t6_ev", 0, ev[0], 1);
        chk("t6_ed", 0, ed[0], 12'o7777);
`ifdef MEM_PARITY_EN
        chk("t6_err", 0, me[0], 1);
`else
        chk("t6_err", 0, me[0], 0);
`endif
        pe();
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
